// File: rtl/chanlink_l1a_sched_pkg.sv
// Shared definitions for the L1A readout scheduler: FSM encoding and queue entry layout.
package chanlink_l1a_sched_pkg;

    localparam int L1A_DW = 37;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    typedef struct packed {
        logic              mlt;
        logic              ovlp;
        logic [L1A_DW-1:0] data;
    } l1a_ent_t;

    localparam int ENT_W = $bits(l1a_ent_t);

endpackage

// File: rtl/chanlink_l1a_q.sv
// Synchronous FIFO holding pending L1As; a push into a full queue is taken when a pop frees a slot.
module chanlink_l1a_q #(
    parameter int DEPTH = 4,
    parameter int W     = 39
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: only entries counted by cnt_q are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/chanlink_l1a_sched.sv
// L1A readout scheduler: queues L1As, tags overlaps from trigger spacing and launches one ring readout per L1A.
module chanlink_l1a_sched
    import chanlink_l1a_sched_pkg::*;
#(
    parameter int QDEPTH  = 4,
    parameter int TMO_CYC = 1023,
    parameter int GAP_CYC = 2
) (
    input  logic              RCLK,
    input  logic              RST_B,
    input  logic [6:0]        SAMP_MAX,
    input  logic              L1A_IN,
    input  logic [L1A_DW-1:0] L1A_DATA_IN,
    input  logic              LAST_WRD,
    output logic              TRIG_OUT,
    output logic              L1A_WRT_EN,
    output logic [L1A_DW-1:0] L1A_EVT_DATA,
    output logic              OVLP,
    output logic              MLT_OVLP,
    output logic              QFULL,
    output logic [7:0]        DROP_CNT,
    output logic              TMO_ERR,
    output logic [1:0]        SCHED_ST
);

    logic [1:0] st_q, st_d;
    logic [9:0] tmr_q, tmr_d;
    logic [7:0] spc_q, drop_q;
    logic       prev_ovlp_q, tmo_q, trig_q, tmo_set;
    l1a_ent_t   evt_q, push_ent, head_ent;
    logic       q_full, q_empty, pop, accept, drop, ovlp, mlt;

    assign pop    = (st_q == ST_LAUNCH);
    assign accept = L1A_IN & (~q_full | pop);
    assign drop   = L1A_IN & q_full & ~pop;
    assign ovlp   = (spc_q <= {1'b0, SAMP_MAX});
    assign mlt    = ovlp & prev_ovlp_q;
    assign push_ent = '{mlt: mlt, ovlp: ovlp, data: L1A_DATA_IN};

    chanlink_l1a_q #(.DEPTH(QDEPTH), .W(ENT_W)) u_q (
        .clk_i  (RCLK),
        .rst_ni (RST_B),
        .push_i (L1A_IN),
        .pop_i  (pop),
        .din_i  (push_ent),
        .dout_o (head_ent),
        .full_o (q_full),
        .empty_o(q_empty)
    );

    // One timer serves both WAIT_DONE (timeout) and GAP (idle spacing).
    always_comb begin
        st_d    = st_q;
        tmr_d   = '0;
        tmo_set = 1'b0;
        unique case (st_q)
            ST_IDLE:   if (!q_empty) st_d = ST_LAUNCH;
            ST_LAUNCH: st_d = ST_WAIT;
            ST_WAIT: begin
                if (LAST_WRD) begin
                    st_d = ST_GAP;
                end else if (tmr_q == 10'(TMO_CYC - 1)) begin
                    st_d    = ST_GAP;
                    tmo_set = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_q == 10'(GAP_CYC - 1)) st_d = ST_IDLE;
                else                           tmr_d = tmr_q + 1'b1;
            end
        endcase
    end

    always_ff @(posedge RCLK or negedge RST_B) begin
        if (!RST_B) begin
            st_q        <= ST_IDLE;
            tmr_q       <= '0;
            spc_q       <= 8'hFF;
            prev_ovlp_q <= 1'b0;
            drop_q      <= '0;
            tmo_q       <= 1'b0;
            trig_q      <= 1'b0;
            evt_q       <= '0;
        end else begin
            st_q   <= st_d;
            tmr_q  <= tmr_d;
            trig_q <= pop;
            if (pop) evt_q <= head_ent;
            if (accept) begin
                spc_q       <= '0;
                prev_ovlp_q <= ovlp;
            end else if (spc_q != 8'hFF) begin
                spc_q <= spc_q + 1'b1;
            end
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
            if (tmo_set) tmo_q <= 1'b1;
        end
    end

    assign TRIG_OUT     = trig_q;
    assign L1A_WRT_EN   = trig_q;
    assign L1A_EVT_DATA = evt_q.data;
    assign OVLP         = evt_q.ovlp;
    assign MLT_OVLP     = evt_q.mlt;
    assign QFULL        = q_full;
    assign DROP_CNT     = drop_q;
    assign TMO_ERR      = tmo_q;
    assign SCHED_ST     = st_q;

endmodule

// File: tb/tb_chanlink_l1a_sched.sv
// Scoreboard bench for chanlink_l1a_sched: a timestamp-level model predicts launches and status each cycle.
module tb_chanlink_l1a_sched;

    localparam int QD  = 4;
    localparam int TMO = 60;
    localparam int GAP = 2;

    logic        RCLK = 1'b0;
    logic        RST_B;
    logic [6:0]  SAMP_MAX;
    logic        L1A_IN;
    logic [36:0] L1A_DATA_IN;
    logic        LAST_WRD;
    logic        TRIG_OUT, L1A_WRT_EN, OVLP, MLT_OVLP, QFULL, TMO_ERR;
    logic [36:0] L1A_EVT_DATA;
    logic [7:0]  DROP_CNT;
    logic [1:0]  SCHED_ST;

    chanlink_l1a_sched #(.QDEPTH(QD), .TMO_CYC(TMO), .GAP_CYC(GAP)) dut (
        .RCLK(RCLK), .RST_B(RST_B), .SAMP_MAX(SAMP_MAX), .L1A_IN(L1A_IN),
        .L1A_DATA_IN(L1A_DATA_IN), .LAST_WRD(LAST_WRD), .TRIG_OUT(TRIG_OUT),
        .L1A_WRT_EN(L1A_WRT_EN), .L1A_EVT_DATA(L1A_EVT_DATA), .OVLP(OVLP),
        .MLT_OVLP(MLT_OVLP), .QFULL(QFULL), .DROP_CNT(DROP_CNT), .TMO_ERR(TMO_ERR),
        .SCHED_ST(SCHED_ST)
    );

    always #5 RCLK = ~RCLK;

    int cyc = 0;
    always @(posedge RCLK) cyc <= cyc + 1;

    typedef struct { logic [36:0] d; bit ov; bit ml; int pc; } ent_t;
    typedef struct { int cyc; logic [36:0] d; bit ov; bit ml; } lexp_t;
    typedef struct { int cyc; bit qf; int drop; bit tmo; int st; } sexp_t;

    ent_t  mq[$];
    lexp_t lq[$];
    sexp_t stq[$];

    // Reference model: trigger spacing, drops and readout occupancy kept as timestamps.
    int m_spc, m_drop, idle_from, trig, dly, dly_lo, dly_hi, samp;
    bit m_prev, m_tmo, act, spur;
    int n_chk = 0, n_err = 0;
    int trig_total = 0, trig_base = 0;

    task automatic chk(input string nm, input longint act_v, input longint exp_v);
        n_chk++;
        if (act_v != exp_v) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act_v, exp_v);
        end
    endtask

    always @(negedge RCLK) begin
        sexp_t s;
        lexp_t l;
        if (RST_B) begin
            if (stq.size() > 0 && stq[0].cyc == cyc) begin
                s = stq.pop_front();
                chk("qfull",    QFULL,    s.qf);
                chk("drop_cnt", DROP_CNT, s.drop);
                chk("tmo_err",  TMO_ERR,  s.tmo);
                chk("sched_st", SCHED_ST, s.st);
            end
            if (TRIG_OUT || L1A_WRT_EN) begin
                trig_total++;
                if (lq.size() == 0) chk("unexpected_launch", 1, 0);
                else begin
                    l = lq.pop_front();
                    chk("launch_cyc", cyc, l.cyc);
                    chk("trig_out",   TRIG_OUT, 1);
                    chk("wrt_en",     L1A_WRT_EN, 1);
                    chk("evt_data",   L1A_EVT_DATA, l.d);
                    chk("ovlp",       OVLP, l.ov);
                    chk("mlt_ovlp",   MLT_OVLP, l.ml);
                end
            end else if (lq.size() > 0 && lq[0].cyc <= cyc) begin
                l = lq.pop_front();
                chk("launch_missing", TRIG_OUT, 1);
            end
        end
    end

    function automatic bit pop_now(input int c);
        return !act && (c - 1 >= idle_from) && mq.size() > 0 && mq[0].pc <= c - 2;
    endfunction

    task automatic step(input bit l1a);
        int c;
        bit pop, full, lw, ov, ml;
        sexp_t s;
        ent_t e;
        logic [63:0] r;
        logic [36:0] d;
        c = cyc;
        pop = pop_now(c);
        s.cyc = c; s.qf = (mq.size() == QD); s.drop = m_drop; s.tmo = m_tmo;
        s.st = pop ? 1 : act ? 2 : (c < idle_from) ? 3 : 0;
        stq.push_back(s);
        full = (mq.size() == QD);
        if (pop) begin
            e = mq.pop_front();
            act = 1; trig = c + 1;
            dly = $urandom_range(dly_hi, dly_lo);
            lq.push_back('{c + 1, e.d, e.ov, e.ml});
        end
        r = {$urandom, $urandom};
        d = r[36:0];
        if (l1a && (!full || pop)) begin
            ov = (m_spc <= samp);
            ml = ov && m_prev;
            mq.push_back('{d, ov, ml, c});
            m_prev = ov;
            m_spc = 0;
        end else begin
            if (l1a && m_drop < 255) m_drop++;
            if (m_spc < 255) m_spc++;
        end
        lw = 0;
        if (act && c >= trig) begin
            if (c == trig + dly) begin
                lw = 1; act = 0; idle_from = c + GAP + 1;
            end else if (c == trig + TMO - 1) begin
                act = 0; m_tmo = 1; idle_from = c + GAP + 1;
            end
        end else if (spur && $urandom_range(7, 0) == 0) lw = 1;
        SAMP_MAX = 7'(samp); L1A_IN = l1a; L1A_DATA_IN = d; LAST_WRD = lw;
        @(posedge RCLK); #1;
    endtask

    task automatic do_reset();
        RST_B = 1'b0; L1A_IN = 1'b0; LAST_WRD = 1'b0;
        #1;
        chk("rst_trig",  TRIG_OUT, 0);
        chk("rst_wrt",   L1A_WRT_EN, 0);
        chk("rst_data",  L1A_EVT_DATA, 0);
        chk("rst_ovlp",  OVLP, 0);
        chk("rst_mlt",   MLT_OVLP, 0);
        chk("rst_qfull", QFULL, 0);
        chk("rst_drop",  DROP_CNT, 0);
        chk("rst_tmo",   TMO_ERR, 0);
        chk("rst_st",    SCHED_ST, 0);
        stq.delete(); lq.delete(); mq.delete();
        m_spc = 255; m_prev = 0; m_drop = 0; m_tmo = 0; act = 0;
        repeat (3) @(posedge RCLK);
        #1;
        RST_B = 1'b1;
        idle_from = cyc;
        trig_base = trig_total;
    endtask

    task automatic drain();
        int n = 0;
        while ((act || mq.size() > 0 || cyc < idle_from + 2) && n < 2000) begin
            step(0);
            n++;
        end
        if (n >= 2000) chk("drain_timeout", n, 0);
    endtask

    initial begin
        int d0;
        RST_B = 1'b0; L1A_IN = 1'b0; LAST_WRD = 1'b0; L1A_DATA_IN = '0;
        samp = 7; SAMP_MAX = 7'd7; spur = 0; dly_lo = 10; dly_hi = 10;
        @(posedge RCLK); #1;
        do_reset();

        // single L1A, LAST_WRD 10 cycles after TRIG_OUT
        step(1); repeat (25) step(0);

        // spacing 5 then 4 with SAMP_MAX=7
        step(1); repeat (4) step(0); step(1); repeat (3) step(0); step(1);
        drain();

        // back-to-back burst with LAST_WRD withheld, then saturate DROP_CNT
        dly_lo = 9999; dly_hi = 9999;
        repeat (6) step(1);
        repeat (300) step(1);
        drain();
        chk("drop_saturated", DROP_CNT, 255);

        // pure timeout, then LAST_WRD on the timeout cycle
        do_reset();
        step(1); drain();
        chk("tmo_sticky", TMO_ERR, 1);
        do_reset();
        dly_lo = TMO - 1; dly_hi = TMO - 1;
        step(1); drain();
        chk("tmo_same_cycle", TMO_ERR, 0);

        // reset while waiting for LAST_WRD
        dly_lo = 20; dly_hi = 20;
        step(1); repeat (8) step(0);
        do_reset();
        repeat (30) step(0);
        chk("no_trig_after_rst", trig_total - trig_base, 0);

        // L1A arriving exactly when a full queue pops
        dly_lo = 3; dly_hi = 3;
        repeat (5) step(1);
        d0 = m_drop;
        repeat (80) step(pop_now(cyc) && mq.size() == QD);
        chk("drop_on_pop", DROP_CNT, d0);
        drain();

        // randomized traffic; SAMP_MAX only changes while idle
        spur = 1;
        for (int ph = 0; ph < 5; ph++) begin
            int rate;
            samp = (ph == 4) ? 127 : int'($urandom_range(20, 0));
            rate = $urandom_range(6, 1);
            dly_lo = 0;
            dly_hi = (ph % 2 == 0) ? 12 : TMO + 4;
            repeat (1200) step($urandom_range(15, 0) < rate);
            drain();
        end

        chk("launch_q_empty", lq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
